// File: rtl/csa_resolver.sv
// csa_resolver
// Resolves a redundant (sum, carry) pair from a carry-save stage into an exact
// binary value, CHUNK bits per clock, so the carry chain per cycle is only one
// CHUNK-bit adder plus a carry flop.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sum_in/carry_in valid
//   in_ready   block can accept a pair (registered, high only in IDLE)
//   sum_in     redundant sum vector, bit i weight 2^i
//   carry_in   redundant carry vector, bit i weight 2^(i+1)
//   out_valid  result valid (registered)
//   out_ready  downstream accepts result
//   result     sum_in + 2*carry_in, N+2 bits, exact
//
// State  | meaning
// IDLE   | waiting for a pair; in_ready high after the first post-reset edge
// RUN    | resolving chunk k each cycle, carry held in cf
// DONE   | result presented, waiting for out_ready
module csa_resolver #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   sum_in,
    input  logic [N-1:0]   carry_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+1:0]   result
);

    localparam int NCH = N / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    s_q, s_d;
    logic [N:0]      c_q, c_d;
    logic [KW-1:0]   k_q, k_d;
    logic            cf_q, cf_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N+1:0]    result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [31:0]     base;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK-1:0] c_chunk;
    logic [CHUNK:0]  chunk_sum;
    logic [N-1:0]    chunk_mask;
    logic [1:0]      top2;
    logic            last_chunk;
    logic            accept;

    // Chunk selection is done with shifts so the select logic stays a simple
    // barrel indexed by k.
    always_comb begin
        base       = 32'(k_q) * 32'(CHUNK);
        s_chunk    = CHUNK'(s_q >> base);
        c_chunk    = CHUNK'(c_q >> base);
        chunk_sum  = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cf_q};
        chunk_mask = N'({CHUNK{1'b1}}) << base;
        // C[N] is the carry vector's MSB shifted past the sum width; it only
        // meets the last chunk's carry-out in the top two result bits.
        top2       = {1'b0, c_q[N]} + {1'b0, chunk_sum[CHUNK]};
        last_chunk = (k_q == K_LAST);
        accept     = in_valid && in_ready_q;
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        k_d         = k_q;
        cf_d        = cf_q;
        acc_d       = acc_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (accept) begin
                    s_d        = sum_in;
                    c_d        = {carry_in, 1'b0};
                    k_d        = '0;
                    cf_d       = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready_d = 1'b0;
                acc_d      = (acc_q & ~chunk_mask) | (N'(chunk_sum[CHUNK-1:0]) << base);
                cf_d       = chunk_sum[CHUNK];
                k_d        = k_q + 1'b1;
                if (last_chunk) begin
                    result_d    = {top2, acc_d};
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            cf_q        <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            k_q         <= k_d;
            cf_q        <= cf_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_csa_resolver.sv
module tb_csa_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] sum_in    [3];
    logic [7:0] carry_in  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [9:0] result    [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Three configurations of N=8: CHUNK 4 (default), 8 and 1.
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int CH = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
        csa_resolver #(.N(8), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .sum_in    (sum_in[g]),
            .carry_in  (carry_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .result    (result[g])
        );
    end

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [8];

    function automatic int chunk_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 8 : 1);
    endfunction

    // Reference: the plain integer value of the redundant pair.
    function automatic int ref_model(input logic [7:0] s, input logic [7:0] c);
        return int'(s) + 2 * int'(c);
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cfg%0d: got 0x%0h expected 0x%0h", name, g, act, exp);
        end
    endtask

    // One full transaction on configuration g; starts and ends at a negedge.
    task automatic txn(input int g, input logic [7:0] s, input logic [7:0] c,
                       input logic [9:0] exp, input int stall, input bit noise);
        int n;
        int lat;
        int nch;
        nch = 8 / chunk_of(g);
        n = 0;
        while (!in_ready[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[g]) begin
            check("ready_timeout", g, 32'(in_ready[g]), 32'd1);
            return;
        end
        in_valid[g] = 1'b1;
        sum_in[g]   = s;
        carry_in[g] = c;
        @(negedge clk);
        lat = 0;
        in_valid[g] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sum_in[g]   = 8'($urandom);
        carry_in[g] = 8'($urandom);
        check("busy_ready", g, 32'(in_ready[g]), 32'd0);
        check("busy_valid", g, 32'(out_valid[g]), 32'd0);
        while (!out_valid[g] && lat < 40) begin
            @(negedge clk);
            lat++;
            in_valid[g] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check("latency", g, 32'(lat), 32'(nch));
        check("result", g, 32'(result[g]), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid[g] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            check("stall_valid", g, 32'(out_valid[g]), 32'd1);
            check("stall_result", g, 32'(result[g]), 32'(exp));
            check("stall_ready", g, 32'(in_ready[g]), 32'd0);
        end
        out_ready[g] = 1'b1;
        in_valid[g]  = 1'b0;
        @(negedge clk);
        out_ready[g] = 1'b0;
        check("post_valid", g, 32'(out_valid[g]), 32'd0);
        check("post_ready", g, 32'(in_ready[g]), 32'd1);
        check("post_hold", g, 32'(result[g]), 32'(exp));
    endtask

    task automatic run_random(input int g);
        logic [7:0] s;
        logic [7:0] c;
        for (int i = 0; i < 1000; i++) begin
            s = 8'($urandom);
            c = 8'($urandom);
            if (i < 4) begin
                s = i[0] ? 8'hFF : 8'h00;
                c = i[1] ? 8'hFF : 8'h00;
            end
            txn(g, s, c, 10'(ref_model(s, c)), int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        tbl[0] = '{8'h00, 8'h03, 10'h006};
        tbl[1] = '{8'h0F, 8'h01, 10'h011};
        tbl[2] = '{8'hFF, 8'hFF, 10'h2FD};
        tbl[3] = '{8'h00, 8'h00, 10'h000};
        tbl[4] = '{8'h80, 8'h80, 10'h180};
        tbl[5] = '{8'hFF, 8'h00, 10'h0FF};
        tbl[6] = '{8'h00, 8'hFF, 10'h1FE};
        tbl[7] = '{8'h01, 8'h7F, 10'h0FF};

        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            sum_in[g]    = 8'h00;
            carry_in[g]  = 8'h00;
            out_ready[g] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_ready", g, 32'(in_ready[g]), 32'd0);
            check("rst_valid", g, 32'(out_valid[g]), 32'd0);
            check("rst_result", g, 32'(result[g]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 0, 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        for (int g = 0; g < 3; g++)
            check("ready_after_edge", g, 32'(in_ready[g]), 32'd1);

        // Directed vectors on every configuration.
        for (int i = 0; i < 8; i++)
            for (int g = 0; g < 3; g++)
                txn(g, tbl[i].s, tbl[i].c, tbl[i].exp, 0, 1'b0);

        // Backpressure then back-to-back on the default configuration.
        in_valid[0] = 1'b1;
        sum_in[0]   = 8'h12;
        carry_in[0] = 8'h34;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_first_valid", 0, 32'(out_valid[0]), 32'd1);
        check("bp_first_result", 0, 32'(result[0]), 32'h07A);
        in_valid[0] = 1'b1;
        sum_in[0]   = 8'hAB;
        carry_in[0] = 8'hCD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 0, 32'(out_valid[0]), 32'd1);
            check("bp_ready", 0, 32'(in_ready[0]), 32'd0);
            check("bp_result", 0, 32'(result[0]), 32'h07A);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("b2b_idle_valid", 0, 32'(out_valid[0]), 32'd0);
        check("b2b_idle_ready", 0, 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        sum_in[0]   = 8'h00;
        carry_in[0] = 8'h00;
        check("b2b_accepted", 0, 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        check("b2b_hold_prev", 0, 32'(result[0]), 32'h07A);
        check("b2b_not_yet", 0, 32'(out_valid[0]), 32'd0);
        @(negedge clk);
        check("b2b_valid", 0, 32'(out_valid[0]), 32'd1);
        check("b2b_result", 0, 32'(result[0]), 32'h245);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Asynchronous reset in the middle of RUN.
        in_valid[0] = 1'b1;
        sum_in[0]   = 8'hFF;
        carry_in[0] = 8'hFF;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 0, 32'(out_valid[0]), 32'd0);
        check("arst_ready", 0, 32'(in_ready[0]), 32'd0);
        check("arst_result", 0, 32'(result[0]), 32'd0);
        @(negedge clk);
        check("arst_hold_ready", 0, 32'(in_ready[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        check("arst_release_ready", 0, 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        check("arst_ready_up", 0, 32'(in_ready[0]), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        check("arst_no_output", 0, 32'(seen), 32'd0);
        check("arst_result_zero", 0, 32'(result[0]), 32'd0);

        // Random pairs on all three configurations in parallel.
        fork
            run_random(0);
            run_random(1);
            run_random(2);
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate resolver for redundant (sum, carry) vectors produced by the carry-save adder stage. It accepts one redundant pair per transaction over a valid/ready handshake. It resolves the pair into an exact binary result CHUNK bits per cycle, trading latency for a short carry chain. It sits downstream of carry-save compressor trees, replacing the single-cycle full-width final adder where timing is tight.

## Interface
- N, default 8: width of sum_in and carry_in; must be a multiple of CHUNK.
- CHUNK, default 4: bits resolved per cycle; legal range is 1 <= CHUNK <= N.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low (one clock domain; asynchronous assert, active-low fixed).
- in_valid  input  1  sum_in/carry_in valid.
- in_ready  output  1  block can accept a pair.
- sum_in  input  N  redundant sum vector; bit i has weight 2^i.
- carry_in  input  N  redundant carry vector; bit i has weight 2^(i+1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  N+2  exact value sum_in + 2*carry_in.

## Operation
- Arithmetic:
  - result = {2'b0, sum_in} + {1'b0, carry_in, 1'b0}, exact with no truncation.
  - The maximum value is 3*(2^N-1), so N+2 bits are required.
- Capture: on an accept edge (in_valid && in_ready), register S = sum_in and C = {carry_in, 1'b0} (N+1 bits). Clear the chunk counter k and the carry flop cf.
- States:
  - IDLE: in_ready=1, out_valid=0. Accept edge -> RUN.
  - RUN: each cycle, compute S[k*CHUNK +: CHUNK] + C[k*CHUNK +: CHUNK] + cf.
    - Write the low CHUNK bits into internal accumulator bits [k*CHUNK +: CHUNK].
    - cf <= carry-out; k <= k+1.
    - On the edge that processes chunk NCH-1 (NCH = N/CHUNK), load result <= {top2, acc}, where top2 = C[N] + carry-out of the last chunk (2 bits). Go to DONE.
  - DONE: out_valid=1, result stable. Edge with out_ready=1 -> IDLE.
- in_ready and out_valid are registers, updated on the same edges as the state.
  - in_ready=1 exactly while in IDLE after the first post-reset edge.
  - Transactions never overlap. in_valid is ignored outside IDLE.
- result changes only on the final RUN edge. It holds its value after out_valid drops until the next final edge.
- The inputs need not be held after the accept edge.
- Reset (asynchronous, any state, including mid-RUN or DONE):
  - state=IDLE, in_ready=0, out_valid=0, result=0, k=0, cf=0, accumulator=0.
  - The in-flight transaction is discarded; no partial result is ever presented.
  - in_ready rises on the first rising clk edge with rst_n high.

## Timing
- Latency: out_valid rises on the NCH-th rising edge after the accept edge. Defaults give 2 edges; CHUNK=N gives 1.
- A DONE->IDLE edge sets in_ready=1 on that same edge. The next accept is possible on the following edge.
- Minimum initiation interval is NCH+2 cycles (accept, NCH RUN edges, handshake edge).
- Backpressure: with out_ready low, DONE holds indefinitely. out_valid and result stay unchanged and in_ready stays 0.
- out_valid does not depend combinationally on out_ready, and in_ready does not depend combinationally on in_valid.
- The critical path is one CHUNK-bit adder plus cf.

## Test plan
- Reset: pulse rst_n low while in RUN.
  - Required: out_valid=0, result=0 and in_ready=0 immediately (asynchronous); in_ready=1 after the first edge with rst_n high; no out_valid for the aborted pair.
- Basic, N=8/CHUNK=4: sum_in=0x00, carry_in=0x03 (the compressed form of 1+2+3).
  - Required: result=0x006 with out_valid high 2 edges after accept.
- Cross-chunk carry: sum_in=0x0F, carry_in=0x01.
  - Required: result=0x011 (chunk-0 carry-out propagates into chunk 1).
- Maximum: sum_in=0xFF, carry_in=0xFF.
  - Required: result=0x2FD (765); both top bits exercised; no truncation.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles while driving in_valid=1 with a new pair. Required: result, out_valid=1 and in_ready=0 held for all 5 cycles; the new pair is not accepted.
  - Then raise out_ready. Required: IDLE, the second pair accepted on the next edge, and its correct result 2 edges later.
- Parameter sweep:
  - CHUNK=8, N=8: latency 1.
  - CHUNK=1, N=8: latency 8.
  - 1000 random pairs per configuration compared against sum_in + 2*carry_in.
